// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a word FIFO, start/data/parity/stop framing
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [DIV_WIDTH-1:0]          divisor,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;
    logic                 bit_end;
    logic                 last_stop;

    assign ready     = (level < LW'(FIFO_DEPTH));
    assign push      = valid & ready;
    assign head      = mem[rd_ptr];
    assign bit_end   = (baud_cnt == div_q);
    assign last_stop = (state == S_STOP) && bit_end && (bit_cnt == 4'(STOP_BITS - 1));
    // A new frame starts from idle, or seamlessly at the last clock of the final stop bit.
    assign pop       = (level != '0) && ((state == S_IDLE) || last_stop);
    assign busy      = (state != S_IDLE) | (level != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
        end else if (pop) begin
            // Divisor and parity are captured once per frame so later changes wait a frame.
            state    <= S_START;
            tx       <= 1'b0;
            div_q    <= divisor;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= head;
            par_q    <= (^head) ^ (PARITY == 2);
        end else begin
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        tx       <= shreg[0];
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx    <= par_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        tx <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
